// File: rtl/shot_evaluator.sv
// Light-gun shot evaluator: turns mouse click edges into one-cycle hit/miss
// pulses, tracks remaining ammo and enforces a dead time after each shot.
module shot_evaluator #(
  parameter int AMMO_MAX        = 3,
  parameter int COOLDOWN_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mouse_left,
  input  logic       mouse_on_target,
  input  logic       round_start,
  input  logic       round_active,
  output logic       hit,
  output logic       miss,
  output logic [3:0] ammo,
  output logic       out_of_ammo,
  output logic       busy
);

  localparam int            CW        = $clog2(COOLDOWN_CYCLES + 1);
  localparam logic [CW-1:0] CD_LOAD   = CW'(COOLDOWN_CYCLES - 1);
  localparam logic [3:0]    AMMO_FULL = 4'(AMMO_MAX);

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    EVAL,
    COOLDOWN,
    EMPTY
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    ammo_q, ammo_d;
  logic          btn_q, btn_d;
  logic          tgt_q, tgt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          click;

  assign click = mouse_left & ~btn_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ammo_q  <= '0;
      btn_q   <= 1'b0;
      tgt_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ammo_q  <= ammo_d;
      btn_q   <= btn_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
    end
  end

  // round_start outranks everything, including the pulse of an EVAL cycle.
  always_comb begin
    state_d = state_q;
    ammo_d  = ammo_q;
    btn_d   = mouse_left;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    hit     = 1'b0;
    miss    = 1'b0;
    if (round_start) begin
      state_d = ARMED;
      ammo_d  = AMMO_FULL;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: ;
        ARMED: begin
          if (!round_active) begin
            state_d = IDLE;
          end else if (click && (ammo_q != 4'd0)) begin
            tgt_d   = mouse_on_target;
            ammo_d  = ammo_q - 4'd1;
            state_d = EVAL;
          end
        end
        EVAL: begin
          hit  = tgt_q;
          miss = ~tgt_q;
          if (round_active) begin
            state_d = COOLDOWN;
            cnt_d   = CD_LOAD;
          end else begin
            state_d = IDLE;
          end
        end
        COOLDOWN: begin
          if (!round_active) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == '0) begin
            state_d = (ammo_q != 4'd0) ? ARMED : EMPTY;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        EMPTY: begin
          if (!round_active) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign ammo        = ammo_q;
  assign busy        = (state_q == EVAL) || (state_q == COOLDOWN);
  assign out_of_ammo = (state_q == EMPTY) && (ammo_q == 4'd0);

endmodule

// File: tb/tb_shot_evaluator.sv
// Self-checking bench for shot_evaluator: directed scenarios plus random
// stimulus, all compared against a dead-time/ammo reference model.
module tb_shot_evaluator;

  localparam int AM = 3;
  localparam int CD = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mouse_left = 1'b0;
  logic       mouse_on_target = 1'b0;
  logic       round_start = 1'b0;
  logic       round_active = 1'b0;
  logic       hit, miss, out_of_ammo, busy;
  logic [3:0] ammo;

  int check_count = 0;
  int pass_count  = 0;

  // Reference model: "in round" flag, ammo count and remaining dead cycles
  // (EVAL + cooldown) after a shot.
  bit m_active, m_tgt, m_btn;
  int m_ammo, m_dead;

  shot_evaluator #(.AMMO_MAX(AM), .COOLDOWN_CYCLES(CD)) dut (
    .clk(clk), .rst_n(rst_n), .mouse_left(mouse_left),
    .mouse_on_target(mouse_on_target), .round_start(round_start),
    .round_active(round_active), .hit(hit), .miss(miss), .ammo(ammo),
    .out_of_ammo(out_of_ammo), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_count++;
    if (obs === exp) pass_count++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic modelReset();
    m_active = 0; m_tgt = 0; m_btn = 0; m_ammo = 0; m_dead = 0;
  endtask

  task automatic modelEdge(input bit ml, input bit mon, input bit rs, input bit ra);
    bit clk_edge;
    clk_edge = ml && !m_btn;
    m_btn    = ml;
    if (rs) begin
      m_active = 1; m_ammo = AM; m_dead = 0;
    end else if (m_dead == CD + 1) begin
      if (ra) m_dead = CD;
      else begin m_dead = 0; m_active = 0; end
    end else if (m_active && !ra) begin
      m_active = 0; m_dead = 0;
    end else if (m_dead > 0) begin
      m_dead--;
    end else if (m_active && m_ammo > 0 && clk_edge) begin
      m_ammo--; m_dead = CD + 1; m_tgt = mon;
    end
  endtask

  // Drive one cycle of inputs, check every output mid-cycle, then advance the model.
  task automatic applyStimulus(input bit ml, input bit mon, input bit rs, input bit ra);
    bit ev;
    @(negedge clk);
    mouse_left = ml; mouse_on_target = mon; round_start = rs; round_active = ra;
    #1;
    ev = (m_dead == CD + 1);
    checkOutput("hit",         hit,         32'(ev && m_tgt && !rs));
    checkOutput("miss",        miss,        32'(ev && !m_tgt && !rs));
    checkOutput("ammo",        ammo,        32'(m_ammo));
    checkOutput("busy",        busy,        32'(m_dead > 0));
    checkOutput("out_of_ammo", out_of_ammo, 32'(m_active && m_dead == 0 && m_ammo == 0));
    @(posedge clk);
    modelEdge(ml, mon, rs, ra);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 1);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 0; mouse_left = 0; mouse_on_target = 0; round_start = 0; round_active = 0;
    #1;
    checkOutput("rst.hit",  hit,  0);
    checkOutput("rst.miss", miss, 0);
    checkOutput("rst.ammo", ammo, 0);
    checkOutput("rst.busy", busy, 0);
    checkOutput("rst.ooa",  out_of_ammo, 0);
    modelReset();
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    bit ml, rs, ra, mon;
    modelReset();

    // Single hit: pulse one cycle after the click edge, ammo 3 -> 2.
    doReset();
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 0, 1, 1);
    applyStimulus(1, 1, 0, 1);
    #2;
    checkOutput("r30.hit",  hit,  1);
    checkOutput("r30.ammo", ammo, 2);
    checkOutput("r30.busy", busy, 1);
    applyStimulus(0, 0, 0, 1);
    idleCycles(CD + 2);

    // Three misses drain ammo into EMPTY; a fourth click does nothing.
    doReset();
    applyStimulus(0, 0, 1, 1);
    for (int s = 0; s < 3; s++) begin
      applyStimulus(1, 0, 0, 1);
      idleCycles(CD + 2);
    end
    #2;
    checkOutput("r31.ooa",  out_of_ammo, 1);
    checkOutput("r31.ammo", ammo, 0);
    applyStimulus(1, 0, 0, 1);
    #2;
    checkOutput("r31.miss4", miss, 0);
    checkOutput("r31.ammo4", ammo, 0);
    idleCycles(3);

    // Re-click inside cooldown, then hold past its end: one shot only.
    doReset();
    applyStimulus(0, 0, 1, 1);
    applyStimulus(1, 1, 0, 1);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 1);
    for (int i = 0; i < CD + 10; i++) applyStimulus(1, 0, 0, 1);
    #2;
    checkOutput("r32.ammo", ammo, 2);
    checkOutput("r32.busy", busy, 0);
    idleCycles(2);

    // round_start together with a click edge in ARMED.
    applyStimulus(1, 1, 1, 1);
    #2;
    checkOutput("r33.hit",  hit,  0);
    checkOutput("r33.ammo", ammo, 3);
    checkOutput("r33.busy", busy, 0);
    idleCycles(2);

    // round_start during the EVAL cycle.
    applyStimulus(1, 1, 0, 1);
    applyStimulus(0, 0, 1, 1);
    #2;
    checkOutput("r34.ammo", ammo, 3);
    checkOutput("r34.busy", busy, 0);
    idleCycles(2);

    // Reset asserted mid-cooldown with one shot left.
    doReset();
    applyStimulus(0, 0, 1, 1);
    applyStimulus(1, 0, 0, 1);
    idleCycles(CD + 2);
    applyStimulus(1, 1, 0, 1);
    idleCycles(5);
    doReset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 1, 0, 1);
      applyStimulus(0, 0, 0, 1);
    end
    #2;
    checkOutput("r35.ammo", ammo, 0);
    checkOutput("r35.busy", busy, 0);

    // Random traffic, occasional resets.
    ml = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) doReset();
      if ($urandom_range(0, 3) == 0) ml = ~ml;
      rs  = ($urandom_range(0, 39) == 0);
      ra  = ($urandom_range(0, 49) != 0);
      mon = $urandom_range(0, 1) != 0;
      applyStimulus(ml, mon, rs, ra);
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/shot_evaluator.md
SHOT_EVALUATOR -- requirements
Module: shot_evaluator

Interface
REQ-001 Parameter AMMO_MAX, default 3, shots available per round (1..15).
REQ-002 Parameter COOLDOWN_CYCLES, default 16, dead time after each shot in clk cycles (>=1).
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 mouse_left  input  1  left-button level, already synchronous to clk.
REQ-006 mouse_on_target  input  1  registered "mouse over duck" flag from the hit detector.
REQ-007 round_start  input  1  one-cycle pulse that begins a round and reloads ammo.
REQ-008 round_active  input  1  level, high while the round accepts shots.
REQ-009 hit  output  1  one-cycle pulse, the shot landed on the target.
REQ-010 miss  output  1  one-cycle pulse, the shot missed.
REQ-011 ammo  output  4  remaining shots, unsigned.
REQ-012 out_of_ammo  output  1  level, high when ammo == 0 and the block is in EMPTY.
REQ-013 busy  output  1  level, high in EVAL or COOLDOWN.

Function
REQ-014 The block SHALL implement the FSM states IDLE, ARMED, EVAL, COOLDOWN and EMPTY.
REQ-015 The block SHALL register mouse_left into btn_q every cycle, in all states.
- Click edge = mouse_left & ~btn_q.
REQ-016 ARMED, click edge, round_active=1, ammo>0: the block SHALL capture mouse_on_target of that same cycle into tgt_q and go to EVAL.
REQ-017 EVAL (exactly one cycle): the block SHALL assert hit if tgt_q=1, else miss.
- ammo decrements by 1 on the same clock edge that hit or miss rises.
- Next state is COOLDOWN.
- Latency: click edge at cycle N gives the hit/miss pulse at cycle N+1.
REQ-018 COOLDOWN SHALL last exactly COOLDOWN_CYCLES cycles, counted by a down-counter loaded on EVAL exit.
- Exit goes to ARMED if ammo>0, else EMPTY.
- Click edges during COOLDOWN are discarded, not queued.
REQ-019 A button held through the end of COOLDOWN SHALL NOT fire; only a new rising edge fires.
REQ-020 hit and miss SHALL never be high together, and each SHALL be high for exactly one cycle per shot.
REQ-021 ammo SHALL never underflow.
- In EMPTY, click edges are ignored.
- out_of_ammo is 1 only in EMPTY.
REQ-022 round_start SHALL take priority over every other event in every state.
- Effect: ammo <= AMMO_MAX, cooldown counter cleared, state <= ARMED.
- A click edge in the same cycle is ignored.
REQ-023 A round_start arriving during EVAL SHALL suppress that cycle's hit/miss pulse and leave ammo = AMMO_MAX.
REQ-024 round_active=0 in ARMED, COOLDOWN or EMPTY SHALL force IDLE on the next edge.
- ammo is held at its current value.
- EVAL always completes its pulse first, then goes to IDLE instead of COOLDOWN.
REQ-025 IDLE SHALL ignore clicks and leave only on round_start.
REQ-026 busy SHALL equal (state==EVAL || state==COOLDOWN), decoded from registered state.

Reset
REQ-027 While rst_n=0, asynchronously:
- state=IDLE, ammo=0, btn_q=0, tgt_q=0, cooldown counter=0.
- hit=0, miss=0, busy=0, out_of_ammo=0.
REQ-028 After rst_n deasserts, the block SHALL stay in IDLE until round_start.
REQ-029 Reset asserted mid-EVAL or mid-COOLDOWN SHALL abort with no hit/miss pulse emitted after the assertion.

Verification
REQ-030 Reset, round_start, round_active=1; click with mouse_on_target=1 at cycle N -> hit=1 only at N+1, ammo 3->2, busy high for 1+16 cycles.
REQ-031 Three separated clicks with mouse_on_target=0 -> three miss pulses, ammo 3->0.
- State reaches EMPTY, out_of_ammo=1.
- A fourth click gives no pulse and ammo stays 0.
REQ-032 Second click edge 5 cycles after the first (inside COOLDOWN), then button held high past the cooldown end -> exactly one pulse total, ammo decremented once.
REQ-033 round_start and a click edge in the same ARMED cycle -> no pulse, ammo=3, state ARMED.
REQ-034 round_start in the EVAL cycle -> no hit/miss, ammo=3 on the next cycle.
REQ-035 rst_n pulled low during COOLDOWN at ammo=1 -> all outputs 0 immediately; after release, state IDLE and clicks ignored until round_start.
